// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: grants one of two byte requesters to a single UART transmitter.
// Optional feature macro ARB_ROUND_ROBIN_EN: round-robin tie breaking (default build: req0 fixed priority).
module uart_tx_arbiter #(
    parameter int GUARD_CYCLES = 2,
    parameter int BURST_MAX    = 4,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic       ack0,
    output logic       ack1,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    output logic       owner,
    output logic       err_timeout
);

    localparam int BW = (BURST_MAX < 2) ? 1 : $clog2(BURST_MAX + 1);
    localparam int TW = (BUSY_TIMEOUT < 2) ? 1 : $clog2(BUSY_TIMEOUT + 1);
    localparam int GW = (GUARD_CYCLES < 2) ? 1 : $clog2(GUARD_CYCLES + 1);
    localparam logic [BW-1:0] BURST_LIM  = BW'(BURST_MAX);
    localparam logic [TW-1:0] TMO_LAST   = (BUSY_TIMEOUT < 2) ? {TW{1'b0}} : TW'(BUSY_TIMEOUT - 1);
    localparam logic [GW-1:0] GUARD_LAST = (GUARD_CYCLES < 2) ? {GW{1'b0}} : GW'(GUARD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        START     = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4,
        GUARD     = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic [BW-1:0] burst_q, burst_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [GW-1:0] guard_q, guard_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic          tx_start_q, tx_start_d;
    logic          err_q, err_d;

    logic          has_grant_s;
    logic          winner_s;
    logic [BW-1:0] burst_nxt_s;

    // Winner selection and burst bookkeeping; a zero burst count means no grant since reset.
    always_comb begin
        has_grant_s = (burst_q != {BW{1'b0}});
        winner_s    = 1'b0;
        burst_nxt_s = burst_q;
        if (req0 && req1) begin
            if (burst_q >= BURST_LIM) begin
                winner_s = ~owner_q;
            end else begin
`ifdef ARB_ROUND_ROBIN_EN
                winner_s = has_grant_s ? ~owner_q : 1'b0;
`else
                winner_s = 1'b0;
`endif
            end
        end else if (req1) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
        if (!has_grant_s || (winner_s != owner_q)) begin
            burst_nxt_s = BW'(1);
        end else if (burst_q >= BURST_LIM) begin
            burst_nxt_s = BURST_LIM;
        end else begin
            burst_nxt_s = burst_q + BW'(1);
        end
    end

    // Next-state and next-output logic; pulse outputs are registered so they are high during the target state.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        burst_d    = burst_q;
        tmr_d      = tmr_q;
        guard_d    = guard_q;
        tx_data_d  = tx_data_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        tx_start_d = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if ((req0 || req1) && !tx_busy) begin
                    state_d   = LOAD;
                    owner_d   = winner_s;
                    burst_d   = burst_nxt_s;
                    tx_data_d = winner_s ? data1 : data0;
                    ack0_d    = ~winner_s;
                    ack1_d    = winner_s;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                state_d    = START;
                tx_start_d = 1'b1;
            end
            START: begin
                state_d = WAIT_BUSY;
                tmr_d   = TW'(1);
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (tmr_q >= TMO_LAST) begin
                    state_d = GUARD;
                    guard_d = {GW{1'b0}};
                    err_d   = 1'b1;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = GUARD;
                    guard_d = {GW{1'b0}};
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            GUARD: begin
                if (guard_q >= GUARD_LAST) begin
                    state_d = IDLE;
                end else begin
                    guard_d = guard_q + GW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            burst_q    <= {BW{1'b0}};
            tmr_q      <= {TW{1'b0}};
            guard_q    <= {GW{1'b0}};
            tx_data_q  <= 8'h00;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            tx_start_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            burst_q    <= burst_d;
            tmr_q      <= tmr_d;
            guard_q    <= guard_d;
            tx_data_q  <= tx_data_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            tx_start_q <= tx_start_d;
            err_q      <= err_d;
        end
    end

    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign owner       = owner_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus random traffic checked
// against a cycle-timestamp reference model of the grant/handshake rules.
module tb_uart_tx_arbiter;

    localparam int GUARD_CYCLES = 2;
    localparam int BURST_MAX    = 4;
    localparam int BUSY_TIMEOUT = 15;
    localparam int GEFF         = (GUARD_CYCLES == 0) ? 1 : GUARD_CYCLES;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] data0 = 8'h00, data1 = 8'h00;
    logic       tx_busy = 1'b0;
    logic       ack0, ack1, tx_start, owner, err_timeout;
    logic [7:0] tx_data;

    uart_tx_arbiter #(
        .GUARD_CYCLES (GUARD_CYCLES),
        .BURST_MAX    (BURST_MAX),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req0        (req0),
        .req1        (req1),
        .data0       (data0),
        .data1       (data1),
        .ack0        (ack0),
        .ack1        (ack1),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .owner       (owner),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // stimulus intent
    bit         want0, want1, tie_mode, rand_mode, spur_en, u_fix, u_to_next, u_rand_to, rel_req;
    logic [7:0] dat0, dat1;
    int         u_rise = -1, u_fall = -1;

    // reference model: timestamps of the events expected for the byte in flight
    bit         in_fl;
    int         rdy_c, ack_c, start_c, err_c, busy_c;
    bit         m_owner, exp_w, m_any;
    logic [7:0] m_data;
    int         m_burst;

    // observation logs
    int         glog[$];
    int         ack_cycs[$], start_cycs[$], err_cycs[$];
    logic [7:0] start_dat[$];
    int         n_ack0 = 0, n_ack1 = 0, n_err = 0, n_start = 0;
    int         tie_exp[6];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Grant rule: a lone requester wins; a tie goes by burst limit, then by the configured tie policy.
    function automatic bit arbitrate(input bit r0, input bit r1);
        if (r0 && !r1) return 1'b0;
        if (r1 && !r0) return 1'b1;
        if (m_any && m_burst >= BURST_MAX) return !m_owner;
`ifdef ARB_ROUND_ROBIN_EN
        return m_any ? !m_owner : 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        in_fl   = 1'b0;
        rdy_c   = 1 << 30;
        ack_c   = -100;
        start_c = -100;
        err_c   = -100;
        busy_c  = -1;
        m_owner = 1'b0;
        exp_w   = 1'b0;
        m_any   = 1'b0;
        m_data  = 8'h00;
        m_burst = 0;
        u_rise  = -1;
        u_fall  = -1;
        tx_busy = 1'b0;
    endtask

    task automatic step();
        bit b;
        bit w;
        @(negedge clk);
        cyc++;
        check_eq("ack0", 32'(ack0), 32'(cyc == ack_c && !exp_w));
        check_eq("ack1", 32'(ack1), 32'(cyc == ack_c && exp_w));
        check_eq("tx_start", 32'(tx_start), 32'(cyc == start_c));
        check_eq("err_timeout", 32'(err_timeout), 32'(cyc == err_c));
        check_eq("owner", 32'(owner), 32'(m_owner));
        check_eq("tx_data", 32'(tx_data), 32'(m_data));
        if (ack0) begin n_ack0++; glog.push_back(0); ack_cycs.push_back(cyc); end
        if (ack1) begin n_ack1++; glog.push_back(1); ack_cycs.push_back(cyc); end
        if (err_timeout) begin n_err++; err_cycs.push_back(cyc); end
        if (tx_start) begin n_start++; start_cycs.push_back(cyc); start_dat.push_back(tx_data); end

        // requesters hold until acked
        if (ack0 && req0) begin
            req0 = 1'b0;
            if (tie_mode) begin want0 = 1'b1; dat0 = 8'($urandom); end
        end else if (!req0 && want0) begin
            req0 = 1'b1; data0 = dat0; want0 = 1'b0;
        end else if (!req0 && rand_mode && $urandom_range(0, 5) == 0) begin
            req0 = 1'b1; data0 = 8'($urandom);
        end
        if (ack1 && req1) begin
            req1 = 1'b0;
            if (tie_mode) begin want1 = 1'b1; dat1 = 8'($urandom); end
        end else if (!req1 && want1) begin
            req1 = 1'b1; data1 = dat1; want1 = 1'b0;
        end else if (!req1 && rand_mode && $urandom_range(0, 5) == 0) begin
            req1 = 1'b1; data1 = 8'($urandom);
        end

        // UART transmitter model
        if (tx_start) begin
            if (u_to_next || (u_rand_to && $urandom_range(0, 7) == 0)) begin
                u_rise = -1; u_fall = -1; u_to_next = 1'b0;
            end else if (u_fix) begin
                u_rise = cyc + 1; u_fall = cyc + 11;
            end else begin
                u_rise = cyc + $urandom_range(1, 3);
                u_fall = u_rise + $urandom_range(1, 12);
            end
        end
        b = (u_rise >= 0 && cyc >= u_rise && cyc < u_fall);
        if (!b && spur_en && !in_fl && cyc >= rdy_c && $urandom_range(0, 11) == 0) b = 1'b1;
        tx_busy = b;

        if (rel_req) begin
            rst = 1'b0; rel_req = 1'b0; rdy_c = cyc;
        end

        // reference model consumes this cycle's inputs
        if (!rst) begin
            if (!in_fl && cyc >= rdy_c) begin
                if (!b && (req0 || req1)) begin
                    w = arbitrate(req0, req1);
                    if (!m_any || w != m_owner) m_burst = 1;
                    else if (m_burst < BURST_MAX) m_burst++;
                    m_any   = 1'b1;
                    m_owner = w;
                    exp_w   = w;
                    m_data  = w ? data1 : data0;
                    ack_c   = cyc + 1;
                    start_c = cyc + 2;
                    busy_c  = -1;
                    in_fl   = 1'b1;
                end
            end else if (in_fl && cyc > start_c) begin
                if (busy_c < 0) begin
                    if (b) begin
                        busy_c = cyc;
                    end else if (cyc == start_c + BUSY_TIMEOUT - 1) begin
                        err_c = cyc + 1;
                        rdy_c = cyc + 1 + GEFF;
                        in_fl = 1'b0;
                    end
                end else if (!b) begin
                    rdy_c = cyc + 1 + GEFF;
                    in_fl = 1'b0;
                end
            end
        end
    endtask

    task automatic drain(input string tag);
        int k = 0;
        want0 = 1'b0; want1 = 1'b0; tie_mode = 1'b0; rand_mode = 1'b0; spur_en = 1'b0; u_rand_to = 1'b0;
        while (!(!req0 && !req1 && !in_fl && cyc >= rdy_c) && k < 600) begin
            step();
            k++;
        end
        check_eq({tag, "_drain"}, 32'(k >= 600), 32'd0);
    endtask

    initial begin
        int k, ia, is, ie, a0, a1, e0, s0;
        bit sent2;
`ifdef ARB_ROUND_ROBIN_EN
        tie_exp = '{0, 1, 0, 1, 0, 1};
`else
        tie_exp = '{0, 0, 0, 0, 1, 0};
`endif
        model_reset();
        repeat (3) step();
        rel_req = 1'b1;
        step();

        // tie: both requesters held for six bytes from reset
        tie_mode = 1'b1; want0 = 1'b1; want1 = 1'b1; dat0 = 8'h11; dat1 = 8'h22;
        k = 0;
        while (glog.size() < 6 && k < 400) begin step(); k++; end
        check_eq("tie_wait", 32'(k >= 400), 32'd0);
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("tie_seq%0d", i), (glog.size() > i) ? 32'(glog[i]) : 32'hFFFF_FFFF, 32'(tie_exp[i]));
        end
        drain("tie");

        // single requester with fixed UART timing, followed by a second byte to measure the guard gap
        u_fix = 1'b1; dat0 = 8'hA5; want0 = 1'b1;
        ia = ack_cycs.size(); is = start_cycs.size(); a0 = n_ack0; sent2 = 1'b0; k = 0;
        while (n_ack0 < a0 + 2 && k < 300) begin
            step(); k++;
            if (!sent2 && n_ack0 == a0 + 1) begin want0 = 1'b1; dat0 = 8'h5E; sent2 = 1'b1; end
        end
        check_eq("single_wait", 32'(k >= 300), 32'd0);
        if (ack_cycs.size() > ia + 1 && start_cycs.size() > is) begin
            check_eq("single_ack_to_start", 32'(start_cycs[is] - ack_cycs[ia]), 32'd1);
            check_eq("single_txdata", 32'(start_dat[is]), 32'h0000_00A5);
            check_eq("single_guard_gap", 32'(ack_cycs[ia + 1] - (start_cycs[is] + 11)), 32'(GEFF + 2));
        end
        drain("single");
        u_fix = 1'b0;

        // busy never rises; a req1 raised meanwhile must be served afterwards
        u_to_next = 1'b1; dat0 = 8'($urandom); want0 = 1'b1;
        e0 = n_err; a1 = n_ack1; s0 = n_start; is = start_cycs.size(); ie = err_cycs.size(); k = 0;
        while (n_ack1 < a1 + 1 && k < 300) begin
            step(); k++;
            if (n_start == s0 + 1 && !want1 && !req1) begin want1 = 1'b1; dat1 = 8'h77; end
        end
        check_eq("to_wait", 32'(k >= 300), 32'd0);
        drain("to");
        check_eq("to_err_count", 32'(n_err - e0), 32'd1);
        check_eq("to_req1_served", 32'(n_ack1 - a1), 32'd1);
        if (err_cycs.size() > ie && start_cycs.size() > is) begin
            check_eq("to_latency", 32'(err_cycs[ie] - start_cycs[is]), 32'(BUSY_TIMEOUT));
        end

        // req1 rises while the arbiter is in its guard interval
        dat0 = 8'h0F; want0 = 1'b1; a0 = n_ack0; a1 = n_ack1; k = 0;
        while (!(n_ack0 > a0 && !in_fl && cyc < rdy_c) && k < 300) begin step(); k++; end
        check_eq("late_wait_guard", 32'(k >= 300), 32'd0);
        want1 = 1'b1; dat1 = 8'h3C; k = 0;
        while (n_ack1 < a1 + 1 && k < 300) begin step(); k++; end
        check_eq("late_wait_ack", 32'(k >= 300), 32'd0);
        drain("late");
        check_eq("late_ack1_once", 32'(n_ack1 - a1), 32'd1);

        // reset asserted while the byte is in WAIT_DONE
        dat0 = 8'h5A; want0 = 1'b1; a0 = n_ack0; k = 0;
        while (!(in_fl && busy_c >= 0 && cyc > busy_c) && k < 300) begin
            step(); k++;
            if (n_ack0 > a0 && !want1 && !req1) begin want1 = 1'b1; dat1 = 8'hC3; end
        end
        check_eq("rst_wait", 32'(k >= 300), 32'd0);
        #2 rst = 1'b1;
        #1;
        check_eq("rst_ack0", 32'(ack0), 32'd0);
        check_eq("rst_ack1", 32'(ack1), 32'd0);
        check_eq("rst_tx_start", 32'(tx_start), 32'd0);
        check_eq("rst_err", 32'(err_timeout), 32'd0);
        check_eq("rst_tx_data", 32'(tx_data), 32'd0);
        check_eq("rst_owner", 32'(owner), 32'd0);
        model_reset();
        repeat (2) step();
        a0 = n_ack0; a1 = n_ack1; k = 0;
        rel_req = 1'b1;
        while (n_ack1 < a1 + 1 && k < 300) begin step(); k++; end
        check_eq("rst_wait_req1", 32'(k >= 300), 32'd0);
        drain("rst");
        check_eq("rst_no_resend", 32'(n_ack0 - a0), 32'd0);
        check_eq("rst_req1_served", 32'(n_ack1 - a1), 32'd1);

        // random traffic with spurious busy in IDLE and occasional timeouts
        rand_mode = 1'b1; spur_en = 1'b1; u_rand_to = 1'b1;
        repeat (2500) step();
        drain("rand");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
